serial_addsub_engine: RTL and testbench

SERIAL_ADDSUB_ENGINE -- requirements
Module: serial_addsub_engine

---
 rtl/serial_addsub_engine.sv | 167 ++++++++++++++++
 tb/tb_serial_addsub_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_engine.sv
// -----------------------------------------------------------------------------
// serial_addsub_engine
//
// Bit-serial adder/subtractor. Two operands arrive one bit per accepted cycle.
// The full-width result is computed in one cycle and then shifted out one bit
// per accepted cycle. The bit order is selectable and applies to the inputs and
// to the output.
//
// Parameters
//   DATA_WIDTH   operand/result width in bits (2..64)
//   MSB_FIRST    0 = LSB first, 1 = MSB first (inputs and output)
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_en           global enable; all state holds while low
//   i_a, i_b       serial operand bits
//   i_cin          carry-in, sampled with bit 0 of a word (add only)
//   i_sub          0 = add, 1 = subtract, sampled with bit 0 of a word
//   i_din_valid    operand bits valid this cycle
//   o_ready        operand bits accepted this cycle (LOAD phase)
//   o_dout         serial result bit
//   o_dout_valid   o_dout valid this cycle (SHIFT phase)
//   i_ready        downstream accepts o_dout this cycle
//   o_cout         carry-out (add) / no-borrow (sub) of the last result
//   o_ovf          two's-complement overflow of the last result
// -----------------------------------------------------------------------------
module serial_addsub_engine #(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    input  logic i_sub,
    input  logic i_din_valid,
    output logic o_ready,
    output logic o_dout,
    output logic o_dout_valid,
    input  logic i_ready,
    output logic o_cout,
    output logic o_ovf
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   a_sr;
    logic [DATA_WIDTH-1:0]   b_sr;
    logic [DATA_WIDTH-1:0]   r_sr;
    logic                    cin_q;
    logic                    sub_q;
    logic                    in_acc;
    logic                    out_acc;
    logic [DATA_WIDTH+1:0]   calc_res;

    // Shift one bit into a register in the configured serial order. Used with
    // a zero input bit it also serves as the output shift.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] sr,
        input logic                  b
    );
        if (MSB_FIRST)
            return {sr[DATA_WIDTH-2:0], b};
        else
            return {b, sr[DATA_WIDTH-1:1]};
    endfunction

    // Returns {ovf, cout, sum}. Subtraction is A + ~B + 1, so cout is the
    // no-borrow flag and cin plays no part.
    function automatic logic [DATA_WIDTH+1:0] addsub(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic                  cin,
        input logic                  sub
    );
        logic [DATA_WIDTH-1:0] bp;
        logic [DATA_WIDTH:0]   s;
        logic                  ovf;
        bp  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, bp} + {{DATA_WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
        ovf = (a[DATA_WIDTH-1] == bp[DATA_WIDTH-1]) &&
              (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
        return {ovf, s};
    endfunction

    assign in_acc   = i_en & i_din_valid & o_ready;
    assign out_acc  = i_en & i_ready & o_dout_valid;
    assign calc_res = addsub(a_sr, b_sr, cin_q, sub_q);

    // The current result bit sits at the end of the register that leaves first.
    assign o_dout = MSB_FIRST ? r_sr[DATA_WIDTH-1] : r_sr[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= LOAD;
            bit_cnt      <= '0;
            a_sr         <= '0;
            b_sr         <= '0;
            r_sr         <= '0;
            cin_q        <= 1'b0;
            sub_q        <= 1'b0;
            o_cout       <= 1'b0;
            o_ovf        <= 1'b0;
            o_ready      <= 1'b1;
            o_dout_valid <= 1'b0;
        end else if (i_en) begin
            case (state)
                LOAD: begin
                    if (in_acc) begin
                        a_sr <= shift_in(a_sr, i_a);
                        b_sr <= shift_in(b_sr, i_b);
                        if (bit_cnt == '0) begin
                            cin_q <= i_cin;
                            sub_q <= i_sub;
                        end
                        if (bit_cnt == CNT_LAST) begin
                            bit_cnt <= '0;
                            o_ready <= 1'b0;
                            state   <= CALC;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                CALC: begin
                    r_sr         <= calc_res[DATA_WIDTH-1:0];
                    o_cout       <= calc_res[DATA_WIDTH];
                    o_ovf        <= calc_res[DATA_WIDTH+1];
                    o_dout_valid <= 1'b1;
                    state        <= SHIFT;
                end
                SHIFT: begin
                    if (out_acc) begin
                        r_sr <= shift_in(r_sr, 1'b0);
                        if (bit_cnt == CNT_LAST) begin
                            bit_cnt      <= '0;
                            o_dout_valid <= 1'b0;
                            o_ready      <= 1'b1;
                            state        <= LOAD;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    bit_cnt      <= '0;
                    o_ready      <= 1'b1;
                    o_dout_valid <= 1'b0;
                    state        <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_engine.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_engine
//
// Directed bench for serial_addsub_engine at DATA_WIDTH = 8. Two instances run
// in lockstep on the same stimulus: one LSB first and one MSB first. Handshake
// timing does not depend on data, so the instance that matches the bit order
// of the current test is the one whose outputs are checked.
// -----------------------------------------------------------------------------
module tb_serial_addsub_engine;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic a;
    logic b;
    logic cin_s;
    logic sub_s;
    logic din_valid;
    logic ready;

    logic rdy0, dout0, dv0, cout0, ovf0;
    logic rdy1, dout1, dv1, cout1, ovf1;

    bit   msb_sel = 1'b0;
    logic rdy, dout, dv, cout, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_addsub_engine #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_a(a), .i_b(b),
        .i_cin(cin_s), .i_sub(sub_s), .i_din_valid(din_valid),
        .o_ready(rdy0), .o_dout(dout0), .o_dout_valid(dv0), .i_ready(ready),
        .o_cout(cout0), .o_ovf(ovf0)
    );

    serial_addsub_engine #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_a(a), .i_b(b),
        .i_cin(cin_s), .i_sub(sub_s), .i_din_valid(din_valid),
        .o_ready(rdy1), .o_dout(dout1), .o_dout_valid(dv1), .i_ready(ready),
        .o_cout(cout1), .o_ovf(ovf1)
    );

    assign rdy  = msb_sel ? rdy1  : rdy0;
    assign dout = msb_sel ? dout1 : dout0;
    assign dv   = msb_sel ? dv1   : dv0;
    assign cout = msb_sel ? cout1 : cout0;
    assign ovf  = msb_sel ? ovf1  : ovf0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present the first nbits of a word in the selected serial order.
    task automatic send_bits(input logic [7:0] av, input logic [7:0] bv,
                             input logic cin, input logic sub, input int nbits);
        int idx;
        int guard;
        for (int i = 0; i < nbits; i++) begin
            idx       = msb_sel ? 7 - i : i;
            din_valid = 1'b1;
            a         = av[idx];
            b         = bv[idx];
            cin_s     = cin;
            sub_s     = sub;
            guard     = 0;
            while (!rdy && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 50) check("ready timeout", 64'(rdy), 64'(1));
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic run_word(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic cin, input logic sub, input logic [7:0] exp_r,
                            input logic exp_c, input logic exp_o, input bit bp);
        logic [7:0] got;
        logic       held;
        int         idx;
        int         stalls;
        got = '0;
        send_bits(av, bv, cin, sub, 8);
        // One cycle in CALC, then the first result bit.
        check({tag, " calc_not_valid"}, 64'(dv), 64'(0));
        @(posedge clk); #1;
        check({tag, " first_valid"}, 64'(dv), 64'(1));
        check({tag, " cout"}, 64'(cout), 64'(exp_c));
        check({tag, " ovf"}, 64'(ovf), 64'(exp_o));
        for (int i = 0; i < 8; i++) begin
            idx  = msb_sel ? 7 - i : i;
            check($sformatf("%s valid%0d", tag, i), 64'(dv), 64'(1));
            held = dout;
            if (bp) begin
                if (i == 3) begin
                    en = 1'b0;
                    repeat (3) begin
                        @(posedge clk); #1;
                        check($sformatf("%s en_hold%0d", tag, i), 64'({dv, dout}), 64'({1'b1, held}));
                    end
                    en = 1'b1;
                end
                stalls = $urandom_range(0, 3);
                ready  = 1'b0;
                repeat (stalls) begin
                    @(posedge clk); #1;
                    check($sformatf("%s rdy_hold%0d", tag, i), 64'({dv, dout}), 64'({1'b1, held}));
                end
                ready = 1'b1;
            end
            got[idx] = dout;
            @(posedge clk); #1;
        end
        check({tag, " result"}, 64'(got), 64'(exp_r));
        check({tag, " done_not_valid"}, 64'(dv), 64'(0));
        check({tag, " ready_again"}, 64'(rdy), 64'(1));
        check({tag, " flags_held"}, 64'({cout, ovf}), 64'({exp_c, exp_o}));
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        a         = 1'b0;
        b         = 1'b0;
        cin_s     = 1'b0;
        sub_s     = 1'b0;
        din_valid = 1'b0;
        ready     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst ready", 64'(rdy), 64'(1));
        check("rst valid", 64'(dv), 64'(0));
        check("rst dout", 64'(dout), 64'(0));
        check("rst flags", 64'({cout, ovf}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        msb_sel = 1'b0;
        run_word("add_3c_05",  8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0);
        run_word("add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_word("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_word("sub_05_07",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_word("sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_word("bp_5a_33",   8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1);

        // Abort a word part way through; the next bit must start a fresh word.
        send_bits(8'hFF, 8'hFF, 1'b1, 1'b1, 4);
        rst_n = 1'b0;
        #2;
        check("midrst ready", 64'(rdy), 64'(1));
        check("midrst valid", 64'(dv), 64'(0));
        check("midrst dout", 64'(dout), 64'(0));
        check("midrst flags", 64'({cout, ovf}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_word("after_rst_11_22", 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

        msb_sel = 1'b1;
        run_word("msb_a0_0a", 8'hA0, 8'h0A, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
